// File: rtl/multiword_serial_adder_pkg.sv
// Shared types and sizing helpers for the multiword serial adder.
// Holds the FSM state encoding, default geometry and the slice-index width rule.
package multiword_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_WORDS  = 4;

    // A single-slice configuration still needs a 1-bit index register.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    localparam int IDX_W = idx_width(DEFAULT_NUM_WORDS);

endpackage

// File: rtl/multiword_serial_adder_rca.sv
// Ripple-carry adder slice (the team's RCA_8 at its default width).
// Purely combinational: sum/cout = a + b + cin.
module rca_8
    import multiword_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/multiword_serial_adder.sv
// Wide adder that walks one DATA_WIDTH slice per cycle through a single RCA,
// with valid/ready on both sides. `define SIGNED_OVERFLOW_EN adds out_ovf.
module multiword_serial_adder
    import multiword_serial_adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_WORDS  = DEFAULT_NUM_WORDS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] in_a,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0] in_b,
    input  logic                            in_cin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH*NUM_WORDS-1:0] out_sum,
    output logic                            out_cout
`ifdef SIGNED_OVERFLOW_EN
    ,
    output logic                            out_ovf
`endif
);

    localparam int               W        = DATA_WIDTH * NUM_WORDS;
    localparam int               IW       = idx_width(NUM_WORDS);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_WORDS - 1);

    state_t                  state;
    logic [W-1:0]            a_reg;
    logic [W-1:0]            b_reg;
    logic                    carry_reg;
    logic [IW-1:0]           idx;

    logic [DATA_WIDTH-1:0]   slice_a;
    logic [DATA_WIDTH-1:0]   slice_b;
    logic [DATA_WIDTH-1:0]   slice_s;
    logic                    slice_c;

    assign slice_a  = a_reg[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign slice_b  = b_reg[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign in_ready = (state == IDLE);

    rca_8 #(
        .WIDTH (DATA_WIDTH)
    ) u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .sum  (slice_s),
        .cout (slice_c)
    );

`ifdef SIGNED_OVERFLOW_EN
    // The adder does not expose its internal carries; recover the carry into
    // the top bit from the top-bit sum and operands.
    logic top_bit_cin;
    assign top_bit_cin = slice_s[DATA_WIDTH-1] ^ slice_a[DATA_WIDTH-1] ^ slice_b[DATA_WIDTH-1];
`endif

    // NOTE: operand registers are reset along with the control state so an
    // abort mid-operation can never leak a stale slice or carry into the next add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef SIGNED_OVERFLOW_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    out_sum[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= slice_s;
                    carry_reg <= slice_c;
                    if (idx == LAST_IDX) begin
                        out_cout  <= slice_c;
                        out_valid <= 1'b1;
`ifdef SIGNED_OVERFLOW_EN
                        out_ovf   <= top_bit_cin ^ slice_c;
`endif
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_serial_adder.sv
// Self-checking bench for multiword_serial_adder: directed vectors, hand-written
// back-pressure and reset sequences, then random operands against a reference sum.
module tb_multiword_serial_adder;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int W  = DW * NW;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef SIGNED_OVERFLOW_EN
    logic         out_ovf;
`endif

    multiword_serial_adder #(
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
`ifdef SIGNED_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_hs     = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   n_acc <= n_acc + 1;
            if (out_valid && out_ready) n_hs  <= n_hs + 1;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic and the sign-rule for overflow.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Starts and ends at a negedge. Accepts one operation, measures latency,
    // optionally stalls in DONE (poking in_valid), then completes the handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall, input bit poke,
                          output logic [W-1:0] sum, output logic cout, output logic ovf,
                          output int lat, output bit ok_ready, output bit ok_stable);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        ok_ready = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            if (in_ready) ok_ready = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        sum = out_sum;
        cout = out_cout;
`ifdef SIGNED_OVERFLOW_EN
        ovf = out_ovf;
`else
        ovf = 1'b0;
`endif
        ok_stable = out_valid;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || out_sum !== sum || out_cout !== cout || in_ready) ok_stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (out_valid || !in_ready || out_sum !== sum || out_cout !== cout) ok_stable = 1'b0;
    endtask

    initial begin
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [W:0]   r;
        int           lat;
        bit           ok_ready;
        bit           ok_stable;
        int           acc0;
        int           hs0;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_out_cout", 64'(out_cout), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, sum, cout, ovf, lat, ok_ready, ok_stable);
            check($sformatf("vec%0d_sum", i), 64'(sum), 64'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 64'(cout), 64'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NW));
            check($sformatf("vec%0d_in_ready_busy", i), 64'(ok_ready), 64'd1);
            check($sformatf("vec%0d_handshake", i), 64'(ok_stable), 64'd1);
`ifdef SIGNED_OVERFLOW_EN
            check($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(vecs[i].exp_ovf));
`endif
        end

        // Back-pressure: three stalled cycles in DONE with in_valid poked high.
        acc0 = n_acc;
        hs0  = n_hs;
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 3, 1'b1, sum, cout, ovf, lat, ok_ready, ok_stable);
        check("bp_sum", 64'(sum), 64'h2345_678A);
        check("bp_stable", 64'(ok_stable), 64'd1);
        check("bp_in_ready_busy", 64'(ok_ready), 64'd1);
        check("bp_single_accept", 64'(n_acc - acc0), 64'd1);
        check("bp_single_handshake", 64'(n_hs - hs0), 64'd1);
        run_op(32'h0000_0005, 32'h0000_0006, 1'b0, 0, 1'b0, sum, cout, ovf, lat, ok_ready, ok_stable);
        check("bp_second_sum", 64'(sum), 64'h0000_000B);
        check("bp_second_ready", 64'(ok_ready), 64'd1);

        // Reset during the second ADD cycle, after slice 0 produced a carry.
        in_a     = 32'hFFFF_FFFF;
        in_b     = 32'h0000_0001;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_out_sum", 64'(out_sum), 64'd0);
        check("midreset_out_cout", 64'(out_cout), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 0, 1'b0, sum, cout, ovf, lat, ok_ready, ok_stable);
        check("postreset_sum", 64'(sum), 64'h0000_0003);
        check("postreset_cout", 64'(cout), 64'd0);
        check("postreset_latency", 64'(lat), 64'(NW));

        // Random operands with random stalls against the reference model.
        acc0 = n_acc;
        hs0  = n_hs;
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            r = ref_sum(a, b, c);
            run_op(a, b, c, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   sum, cout, ovf, lat, ok_ready, ok_stable);
            check($sformatf("rand%0d_sum", i), 64'({cout, sum}), 64'(r));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(NW));
            check($sformatf("rand%0d_protocol", i), 64'({ok_ready, ok_stable}), 64'b11);
`ifdef SIGNED_OVERFLOW_EN
            check($sformatf("rand%0d_ovf", i), 64'(ovf), 64'(ref_ovf(a, b, r[W-1:0])));
`endif
        end
        @(negedge clk);
        check("rand_accept_count", 64'(n_acc - acc0), 64'd200);
        check("rand_handshake_count", 64'(n_hs - hs0), 64'd200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiword_serial_adder.md
Name: multiword_serial_adder

Overview:
- Sequential wide-operand adder that adds two NUM_WORDS*DATA_WIDTH-bit operands one slice per cycle.
- Uses a single DATA_WIDTH-bit ripple-carry slice and carries between slices through a register.
- Sits directly around the team's 8-bit ripple-carry adder. It feeds that adder byte operands plus a registered carry-in, and consumes its SUM/COUT.
- Exposes valid/ready handshakes on both the operand side and the result side.

Parameters:
- DATA_WIDTH, 8, width of one adder slice in bits.
- NUM_WORDS, 4, number of slices per operand (minimum 1); total width W = DATA_WIDTH*NUM_WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry into slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  A+B+cin modulo 2^W.
- out_cout  output  1  carry out of the top slice.

Behaviour:
- One clock domain. Reset is asynchronous and active-low; all flops clear immediately when rst_n falls.
- Reset values: state=IDLE, out_valid=0, out_sum=0, out_cout=0, slice index=0, carry register=0.
- in_ready is combinational and equals (state==IDLE).
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On in_valid&&in_ready, latch in_a, in_b, and in_cin into the carry register.
  - Set index=0 and go to ADD.
  - With no accept, stay in IDLE.
- ADD, one slice per cycle:
  - {c, s} = a[idx] + b[idx] + carry_reg, where the sum is DATA_WIDTH+1 bits wide.
  - Write s into out_sum slice idx; carry_reg <= c.
  - If idx==NUM_WORDS-1: out_cout <= c, out_valid <= 1, go to DONE. Otherwise idx <= idx+1.
- DONE:
  - out_valid=1. out_sum and out_cout are held stable until out_valid&&out_ready.
  - On that handshake, go to IDLE and clear out_valid. out_sum and out_cout keep their values.
- Latency: with the accept at edge k, out_valid rises after edge k+NUM_WORDS.
- Throughput: one operation per NUM_WORDS+2 cycles at best. There is no overlap; in_ready stays 0 in ADD and DONE.
- in_valid, in_a and in_b are ignored outside IDLE. Held upstream data is not double-accepted.
- out_ready is ignored unless out_valid=1.
- Reset mid-ADD or mid-DONE abandons the operation. All outputs return to reset values and no partial result is presented.
- NUM_WORDS=1 degenerates to a 1-cycle ADD. The index register is at least 1 bit wide.
- Partially written out_sum slices during ADD are undefined to observers; only the value under out_valid is meaningful.

Optional Feature:
- Macro SIGNED_OVERFLOW_EN.
- Defined:
  - Adds output port out_ovf, 1 bit, reset 0.
  - out_ovf is set in the final ADD cycle to (carry into the top bit) XOR (carry out of the top bit), i.e. two's-complement overflow of the W-bit add.
  - out_ovf is held with out_sum.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State enum typedef {IDLE, ADD, DONE}.
  - Default constants DATA_WIDTH=8 and NUM_WORDS=4.
  - An index-width localparam, $clog2 of NUM_WORDS with a minimum of 1.
- One sub-module is natural: the existing 8-bit ripple-carry adder (RCA_8), instantiated once as the per-slice datapath.
  - A, B and CIN are driven by the selected slices and carry_reg.
  - SUM and COUT are captured by this block.
  - The top-bit carry-in for SIGNED_OVERFLOW_EN is derived locally as s[MSB]^a[MSB]^b[MSB].

Test Plan:
- A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid rising exactly 4 cycles after accept.
- A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0; in_ready=0 from accept until the DONE handshake.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, out_sum and out_cout stable; in_ready=0; a new in_valid is not accepted. Then out_ready=1 -> IDLE next cycle, and the second operation is accepted afterwards.
- Reset: drop rst_n during the 2nd ADD cycle -> out_valid=0, out_sum=0 and in_ready=1 immediately. Release and run A=0x00000001, B=0x00000002 -> 0x00000003, no stale carry.
- SIGNED_OVERFLOW_EN defined: A=0x7FFFFFFF, B=0x00000001 -> out_sum=0x80000000, out_ovf=1, out_cout=0. A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE, out_ovf=0, out_cout=1.
- 200 random operand/cin pairs with random out_ready stalls -> every result equals a 33-bit reference sum; exactly one out_valid handshake per accept.
